// File: rtl/julia_pkg.sv
// Shared types and fixed-point constants for the Julia-set line renderer.
package julia_pkg;

  localparam int unsigned COORD_W = 32;
  localparam int unsigned ITER_W  = 4;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned FRAC    = 12;
  // Squared-magnitude width: two 64-bit squares can sum past the signed 64-bit range
  localparam int unsigned MAG_W   = 66;

  localparam logic signed [MAG_W-1:0] ESCAPE_R2 = MAG_W'(64'sd4) <<< FRAC;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic [ITER_W-1:0]         iter_t;
  typedef logic [ADDR_W-1:0]         addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/julia_line_renderer_if.sv
// Request / line-buffer write bundle of the renderer; cx/cy exist only when JULIA_ANIM_EN is defined.
interface julia_line_renderer_if import julia_pkg::*; ();

  logic   start;
  addr_t  line_y;
`ifdef JULIA_ANIM_EN
  coord_t cx;
  coord_t cy;
`endif
  logic   busy;
  logic   done;
  logic   wr_en;
  addr_t  wr_addr;
  iter_t  wr_data;

`ifdef JULIA_ANIM_EN
  modport master (output start, line_y, cx, cy,
                  input  busy, done, wr_en, wr_addr, wr_data);
  modport slave  (input  start, line_y, cx, cy,
                  output busy, done, wr_en, wr_addr, wr_data);
`else
  modport master (output start, line_y,
                  input  busy, done, wr_en, wr_addr, wr_data);
  modport slave  (input  start, line_y,
                  output busy, done, wr_en, wr_addr, wr_data);
`endif

endinterface

// File: rtl/julia_step.sv
// One Julia iteration z' = z^2 + c in signed fixed point, plus the |z|^2 >= 4 escape test on the current z.
module julia_step
  import julia_pkg::*;
#(
  parameter int unsigned FRAC = julia_pkg::FRAC
) (
  input  coord_t zx_i,
  input  coord_t zy_i,
  input  coord_t cx_i,
  input  coord_t cy_i,
  output coord_t zx_c_o,
  output coord_t zy_c_o,
  output logic   escape_c_o
);

  // Radius 2 squared, rescaled from the package fraction to this instance's fraction
  localparam logic signed [MAG_W-1:0] ESC_THR = (ESCAPE_R2 >>> julia_pkg::FRAC) <<< FRAC;

  logic signed [63:0]      xx;
  logic signed [63:0]      yy;
  logic signed [63:0]      xy;
  logic signed [MAG_W-1:0] mag;

  assign xx = 64'(zx_i) * 64'(zx_i);
  assign yy = 64'(zy_i) * 64'(zy_i);
  assign xy = 64'(zx_i) * 64'(zy_i);

  assign mag        = (MAG_W'(xx) + MAG_W'(yy)) >>> FRAC;
  assign escape_c_o = (mag >= ESC_THR);

  // 2*zx*zy folded into the shift; results wrap to 32 bits
  assign zx_c_o = COORD_W'((xx - yy) >>> FRAC) + cx_i;
  assign zy_c_o = COORD_W'(xy >>> (FRAC - 1)) + cy_i;

endmodule

// File: rtl/julia_line_renderer.sv
// Renders one scanline of escape counts, one iteration per clock, into an external line buffer.
// Optional JULIA_ANIM_EN: c is taken from the cx/cy bus fields on each accepted start instead of CX_INIT/CY_INIT.
module julia_line_renderer
  import julia_pkg::*;
#(
  parameter int unsigned H_RES    = 1280,
  parameter int unsigned V_RES    = 720,
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned FRAC     = julia_pkg::FRAC,
  parameter int unsigned SCALE_SH = 4,
  parameter coord_t      CX_INIT  = 32'sh0,
  parameter coord_t      CY_INIT  = 32'sh1000
) (
  input logic                  clk,
  input logic                  rst,
  julia_line_renderer_if.slave bus
);

  localparam addr_t  X_LAST = ADDR_W'(H_RES - 1);
  localparam coord_t X_CTR  = COORD_W'(H_RES / 2);
  localparam coord_t Y_CTR  = COORD_W'(V_RES / 2);
  localparam iter_t  N_MAX  = ITER_W'(MAX_ITER);

  state_e state_q, state_d;
  addr_t  x_q, x_d;
  addr_t  line_y_q, line_y_d;
  coord_t zx_q, zx_d;
  coord_t zy_q, zy_d;
  iter_t  n_q, n_d;

  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   wr_en_q, wr_en_d;
  addr_t  wr_addr_q, wr_addr_d;
  iter_t  wr_data_q, wr_data_d;

  coord_t c_re;
  coord_t c_im;
  coord_t zx_nxt;
  coord_t zy_nxt;
  logic   escape;
  logic   iter_stop;

`ifdef JULIA_ANIM_EN
  coord_t cx_q, cx_d;
  coord_t cy_q, cy_d;
  assign c_re = cx_q;
  assign c_im = cy_q;
`else
  assign c_re = CX_INIT;
  assign c_im = CY_INIT;
`endif

  julia_step #(.FRAC(FRAC)) u_step (
    .zx_i       (zx_q),
    .zy_i       (zy_q),
    .cx_i       (c_re),
    .cy_i       (c_im),
    .zx_c_o     (zx_nxt),
    .zy_c_o     (zy_nxt),
    .escape_c_o (escape)
  );

  assign iter_stop = escape || (n_q == N_MAX);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_ITER;
      ST_ITER:  if (iter_stop) state_d = ST_WRITE;
      ST_WRITE: state_d = (x_q == X_LAST) ? ST_DONE : ST_LOAD;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_d)
      ST_LOAD, ST_ITER: busy_d = 1'b1;
      ST_WRITE: begin
        busy_d    = 1'b1;
        wr_en_d   = 1'b1;
        wr_addr_d = x_q;
        wr_data_d = n_q;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    x_d      = x_q;
    line_y_d = line_y_q;
    zx_d     = zx_q;
    zy_d     = zy_q;
    n_d      = n_q;
`ifdef JULIA_ANIM_EN
    cx_d     = cx_q;
    cy_d     = cy_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          line_y_d = bus.line_y;
          x_d      = '0;
`ifdef JULIA_ANIM_EN
          cx_d     = bus.cx;
          cy_d     = bus.cy;
`endif
        end
      end
      ST_LOAD: begin
        zx_d = ($signed(COORD_W'(x_q)) - X_CTR) <<< SCALE_SH;
        zy_d = ($signed(COORD_W'(line_y_q)) - Y_CTR) <<< SCALE_SH;
        n_d  = '0;
      end
      ST_ITER: begin
        if (!iter_stop) begin
          zx_d = zx_nxt;
          zy_d = zy_nxt;
          n_d  = n_q + ITER_W'(1);
        end
      end
      ST_WRITE: if (x_q != X_LAST) x_d = x_q + ADDR_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      line_y_q  <= '0;
      zx_q      <= '0;
      zy_q      <= '0;
      n_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef JULIA_ANIM_EN
      cx_q      <= CX_INIT;
      cy_q      <= CY_INIT;
`endif
    end else begin
      x_q       <= x_d;
      line_y_q  <= line_y_d;
      zx_q      <= zx_d;
      zy_q      <= zy_d;
      n_q       <= n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef JULIA_ANIM_EN
      cx_q      <= cx_d;
      cy_q      <= cy_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_julia_line_renderer.sv
// Scoreboard bench for julia_line_renderer: stimulus pushes expected writes/done, a negedge monitor pops and compares.
module tb_julia_line_renderer;
  import julia_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  julia_line_renderer_if bus ();

  julia_line_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam coord_t C_RE   = 32'sh0;
  localparam coord_t C_A_IM = 32'sh1000;
`ifdef JULIA_ANIM_EN
  localparam coord_t C_B_IM = 32'sh0;
`else
  localparam coord_t C_B_IM = 32'sh1000;
`endif
  localparam int TIMEOUT = 30000;

  typedef struct {
    bit is_done;
    int addr;
    int data;
    bit hand;
    int hand_data;
    int hand_gap;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int last_wr_cyc = 0;
  int last_done_cyc = 0;
  int done_cnt = 0;
  bit busy_prev = 1'b0;
  bit done_prev = 1'b0;
  bit held_chk = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Escape count straight from the pixel-mapping and iteration formulas
  function automatic int model_n(input int x, input int y, input coord_t cr, input coord_t ci);
    coord_t zx, zy;
    logic signed [63:0] xx, yy, xy;
    logic signed [65:0] mag;
    zx = 32'((x - 640) * 16);
    zy = 32'((y - 360) * 16);
    for (int n = 0; n < 15; n++) begin
      xx  = 64'(zx) * 64'(zx);
      yy  = 64'(zy) * 64'(zy);
      xy  = 64'(zx) * 64'(zy);
      mag = (66'(xx) + 66'(yy)) >>> 12;
      if (mag >= 66'sd16384) return n;
      zx = 32'((xx - yy) >>> 12) + cr;
      zy = 32'(xy >>> 11) + ci;
    end
    return 15;
  endfunction

  task automatic push_line(input int y, input coord_t cr, input coord_t ci,
                           input int hx, input int hd, input int hg);
    exp_t e;
    for (int x = 0; x < 1280; x++) begin
      e.is_done   = 1'b0;
      e.addr      = x;
      e.data      = model_n(x, y, cr, ci);
      e.hand      = (x == hx);
      e.hand_data = hd;
      e.hand_gap  = hg;
      exp_q.push_back(e);
    end
    e = '{is_done: 1'b1, addr: 0, data: 0, hand: 1'b0, hand_data: 0, hand_gap: 0};
    exp_q.push_back(e);
  endtask

  task automatic start_line(input int y);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.line_y = 11'(y);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (done_cnt >= target) break;
    end
    check(name, done_cnt, target);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
  endtask

  // Monitor: every write and done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.busy && !busy_prev) begin
        ref_cyc = cyc - 1;
        if (held_chk) begin
          check("held_restart_cycle", cyc, last_done_cyc + 2);
          held_chk = 1'b0;
        end
      end
      if (done_prev) check("busy_after_done", bus.busy, 0);
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          check("write_when_none_pending", bus.wr_en, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            check("write_instead_of_done", bus.wr_en, 0);
          end else begin
            check("wr_addr", bus.wr_addr, e.addr);
            check("wr_data", bus.wr_data, e.data);
            check("pixel_cycles", cyc - ref_cyc, e.data + 3);
            if (e.hand) begin
              check("hand_wr_data", bus.wr_data, e.hand_data);
              check("hand_pixel_cycles", cyc - ref_cyc, e.hand_gap);
            end
          end
        end
        ref_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", bus.done, 0);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done) check("done_with_writes_pending", bus.done, 0);
          check("done_cycle", cyc, last_wr_cyc + 1);
          check("busy_at_done", bus.busy, 1);
        end
        last_done_cyc = cyc;
        done_cnt++;
      end
    end
    busy_prev = bus.busy;
    done_prev = bus.done;
  end

  initial begin
    bus.start  = 1'b0;
    bus.line_y = '0;
`ifdef JULIA_ANIM_EN
    bus.cx = C_RE;
    bus.cy = C_A_IM;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;

    // Line 0: first pixel escapes immediately, 3 cycles from LOAD
    push_line(0, C_RE, C_A_IM, 0, 0, 3);
    start_line(0);
    wait_done(1, "line0_done");
    check("line0_drained", exp_q.size(), 0);

    // Line 360 with start pulses (and c changes) while busy
`ifdef JULIA_ANIM_EN
    bus.cx = C_RE;
    bus.cy = C_B_IM;
`endif
    push_line(360, C_RE, C_B_IM, 640, 15, 18);
    start_line(360);
    for (int k = 0; k < 4; k++) begin
      repeat (200) @(posedge clk);
      #1 bus.start = 1'b1;
      bus.line_y = 11'd100;
`ifdef JULIA_ANIM_EN
      bus.cx = 32'sh800;
      bus.cy = -32'sh600;
`endif
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    wait_done(2, "line360_done");
    check("line360_drained", exp_q.size(), 0);

    // start held high across DONE: back-to-back lines
`ifdef JULIA_ANIM_EN
    bus.cx = C_RE;
    bus.cy = C_A_IM;
`endif
    push_line(0, C_RE, C_A_IM, 0, 0, 3);
    push_line(0, C_RE, C_A_IM, 0, 0, 3);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.line_y = 11'd0;
    wait_done(3, "held_first_done");
    held_chk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(4, "held_second_done");
    check("held_drained", exp_q.size(), 0);
    check("held_restart_seen", held_chk, 0);

    // Reset while pixel 500 is iterating
    push_line(0, C_RE, C_A_IM, 0, 0, 3);
    start_line(0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (bus.wr_en && bus.wr_addr == 11'd499) break;
    end
    check("reach_x499", bus.wr_addr, 499);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (50) @(negedge clk);
    check("no_done_after_reset", done_cnt, 4);

    // Full line after the mid-line reset
    push_line(0, C_RE, C_A_IM, 0, 0, 3);
    start_line(0);
    wait_done(5, "post_reset_done");
    check("post_reset_drained", exp_q.size(), 0);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
